// File: rtl/ui_control_fsm_pkg.sv
// Shared front-panel types and geometry so the chart renderer and the UI controller
// agree on where the chart window and the button panel live.
package ui_control_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DRAG         = 2'd1,
    STEP         = 2'd2,
    WAIT_RELEASE = 2'd3
  } ui_state_t;

  // Button-panel row order; the row index is the setting index.
  typedef enum logic [2:0] {
    SET_DELAY  = 3'd0,
    SET_MODE   = 3'd1,
    SET_CORNER = 3'd2,
    SET_AMP    = 3'd3,
    SET_TIME   = 3'd4
  } setting_idx_t;

  localparam int UI_CHART_X0   = 64;
  localparam int UI_CHART_Y0   = 64;
  localparam int UI_CHART_W    = 512;
  localparam int UI_CHART_H    = 384;
  localparam int UI_BTN_X0     = 800;
  localparam int UI_BTN_Y0     = 100;
  localparam int UI_BTN_W      = 32;
  localparam int UI_BTN_H      = 32;
  localparam int UI_BTN_PITCH  = 48;
  localparam int UI_OFFSET_LIM = 511;
  localparam int UI_SET_MAX    = 15;
  localparam int UI_MODE_MAX   = 3;
  localparam int UI_DEF_AMP    = 4;
  localparam int UI_DEF_TIME   = 4;

  function automatic logic signed [13:0] clamp_offset(input logic signed [13:0] v,
                                                      input logic signed [13:0] lim);
    logic signed [13:0] r;
    if (v > lim) begin
      r = lim;
    end else if (v < -lim) begin
      r = -lim;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [3:0] step_setting(input logic [3:0] v,
                                              input logic [3:0] max_v,
                                              input logic       up);
    logic [3:0] r;
    if (up) begin
      if (v >= max_v) begin
        r = max_v;
      end else begin
        r = v + 4'd1;
      end
    end else begin
      if (v == 4'd0) begin
        r = 4'd0;
      end else begin
        r = v - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ui_control_fsm_if.sv
// Mouse-position inputs and registered scope settings exchanged with the UI controller.
interface ui_control_fsm_if;

  logic               left_mouse;
  logic        [11:0] xpos;
  logic        [11:0] ypos;
  logic signed [11:0] offset_x;
  logic signed [11:0] offset_y;
  logic               drag_active;
  logic        [3:0]  delay;
  logic        [3:0]  mode;
  logic        [3:0]  corner_freq;
  logic        [3:0]  amplitude_scale;
  logic        [3:0]  time_scale;
  logic               settings_changed;

  modport master (
    output left_mouse, xpos, ypos,
    input  offset_x, offset_y, drag_active, delay, mode, corner_freq,
           amplitude_scale, time_scale, settings_changed
  );

  modport slave (
    input  left_mouse, xpos, ypos,
    output offset_x, offset_y, drag_active, delay, mode, corner_freq,
           amplitude_scale, time_scale, settings_changed
  );

endinterface

// File: rtl/ui_control_fsm_hit_decoder.sv
// Combinational cursor hit test against the chart window and the 5x2 button panel.
module ui_hit_decoder
  import ui_control_fsm_pkg::*;
#(
  parameter int CHART_X0  = UI_CHART_X0,
  parameter int CHART_Y0  = UI_CHART_Y0,
  parameter int CHART_W   = UI_CHART_W,
  parameter int CHART_H   = UI_CHART_H,
  parameter int BTN_X0    = UI_BTN_X0,
  parameter int BTN_Y0    = UI_BTN_Y0,
  parameter int BTN_W     = UI_BTN_W,
  parameter int BTN_H     = UI_BTN_H,
  parameter int BTN_PITCH = UI_BTN_PITCH
) (
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic        chart_hit,
  output logic        btn_hit,
  output logic [2:0]  btn_row,
  output logic        btn_plus
);

  // One spare bit so window edges near 4095 cannot wrap.
  localparam logic [12:0] CX_LO = 13'(CHART_X0);
  localparam logic [12:0] CX_HI = 13'(CHART_X0 + CHART_W);
  localparam logic [12:0] CY_LO = 13'(CHART_Y0);
  localparam logic [12:0] CY_HI = 13'(CHART_Y0 + CHART_H);
  localparam logic [12:0] MX_LO = 13'(BTN_X0);
  localparam logic [12:0] MX_HI = 13'(BTN_X0 + BTN_W);
  localparam logic [12:0] PX_LO = 13'(BTN_X0 + BTN_PITCH);
  localparam logic [12:0] PX_HI = 13'(BTN_X0 + BTN_PITCH + BTN_W);

  logic [12:0] x_s;
  logic [12:0] y_s;
  logic [4:0]  row_vec_s;
  logic        minus_col_s;
  logic        plus_col_s;

  assign x_s = {1'b0, xpos};
  assign y_s = {1'b0, ypos};

  assign chart_hit   = (x_s >= CX_LO) && (x_s < CX_HI) && (y_s >= CY_LO) && (y_s < CY_HI);
  assign minus_col_s = (x_s >= MX_LO) && (x_s < MX_HI);
  assign plus_col_s  = (x_s >= PX_LO) && (x_s < PX_HI);

  for (genvar r = 0; r < 5; r++) begin : g_row
    localparam logic [12:0] ROW_TOP = 13'(BTN_Y0 + r * BTN_PITCH);
    localparam logic [12:0] ROW_BOT = 13'(BTN_Y0 + r * BTN_PITCH + BTN_H);
    assign row_vec_s[r] = (y_s >= ROW_TOP) && (y_s < ROW_BOT);
  end

  // Encode the single active row band into a setting index
  always_comb begin
    btn_row = 3'd0;
    case (row_vec_s)
      5'b00001: btn_row = 3'd0;
      5'b00010: btn_row = 3'd1;
      5'b00100: btn_row = 3'd2;
      5'b01000: btn_row = 3'd3;
      5'b10000: btn_row = 3'd4;
      default:  btn_row = 3'd0;
    endcase
  end

  assign btn_hit  = (row_vec_s != 5'd0) && (minus_col_s || plus_col_s);
  assign btn_plus = plus_col_s;

endmodule

// File: rtl/ui_control_fsm.sv
// Front-panel mouse sequencer: chart drag sessions produce a clamped signed offset,
// button clicks step one scope setting by one with saturation.
module ui_control_fsm
  import ui_control_fsm_pkg::*;
#(
  parameter int CHART_X0   = UI_CHART_X0,
  parameter int CHART_Y0   = UI_CHART_Y0,
  parameter int CHART_W    = UI_CHART_W,
  parameter int CHART_H    = UI_CHART_H,
  parameter int BTN_X0     = UI_BTN_X0,
  parameter int BTN_Y0     = UI_BTN_Y0,
  parameter int BTN_W      = UI_BTN_W,
  parameter int BTN_H      = UI_BTN_H,
  parameter int BTN_PITCH  = UI_BTN_PITCH,
  parameter int OFFSET_LIM = UI_OFFSET_LIM,
  parameter int SET_MAX    = UI_SET_MAX,
  parameter int MODE_MAX   = UI_MODE_MAX,
  parameter int DEF_AMP    = UI_DEF_AMP,
  parameter int DEF_TIME   = UI_DEF_TIME
) (
  input logic           clk,
  input logic           rst,
  ui_control_fsm_if.slave bus
);

  localparam logic signed [13:0] LIM_S      = 14'(OFFSET_LIM);
  localparam logic        [3:0]  SET_MAX_V  = 4'(SET_MAX);
  localparam logic        [3:0]  MODE_MAX_V = 4'(MODE_MAX);
  localparam logic        [3:0]  AMP_RST_V  = 4'(DEF_AMP);
  localparam logic        [3:0]  TIME_RST_V = 4'(DEF_TIME);

  ui_state_t          state_r, state_s;
  logic               left_prev_r;
  logic               press_s;
  logic        [11:0] anchor_x_r, anchor_x_s, anchor_y_r, anchor_y_s;
  logic signed [11:0] base_x_r, base_x_s, base_y_r, base_y_s;
  logic signed [11:0] off_x_r, off_x_s, off_y_r, off_y_s;
  logic               drag_active_r, drag_active_s;
  setting_idx_t       sel_r, sel_s;
  logic               sel_plus_r, sel_plus_s;
  logic        [3:0]  delay_r, delay_s, mode_r, mode_s, corner_r, corner_s;
  logic        [3:0]  amp_r, amp_s, time_r, time_s;
  logic               changed_r, changed_s;
  logic               chart_hit_s, btn_hit_s, btn_plus_s;
  logic        [2:0]  btn_row_s;
  logic signed [13:0] raw_x_s, raw_y_s, drag_x_s, drag_y_s;
  logic        [3:0]  cur_val_s, cur_max_s, new_val_s;

  ui_hit_decoder #(
    .CHART_X0 (CHART_X0),
    .CHART_Y0 (CHART_Y0),
    .CHART_W  (CHART_W),
    .CHART_H  (CHART_H),
    .BTN_X0   (BTN_X0),
    .BTN_Y0   (BTN_Y0),
    .BTN_W    (BTN_W),
    .BTN_H    (BTN_H),
    .BTN_PITCH(BTN_PITCH)
  ) u_hit (
    .xpos     (bus.xpos),
    .ypos     (bus.ypos),
    .chart_hit(chart_hit_s),
    .btn_hit  (btn_hit_s),
    .btn_row  (btn_row_s),
    .btn_plus (btn_plus_s)
  );

  assign press_s = bus.left_mouse & ~left_prev_r;

  // 14-bit signed headroom: |base| <= 511 and |pos - anchor| <= 4095 cannot overflow.
  assign raw_x_s = $signed({{2{base_x_r[11]}}, base_x_r}) + $signed({2'b00, bus.xpos})
                 - $signed({2'b00, anchor_x_r});
  assign raw_y_s = $signed({{2{base_y_r[11]}}, base_y_r}) + $signed({2'b00, bus.ypos})
                 - $signed({2'b00, anchor_y_r});
  assign drag_x_s = clamp_offset(raw_x_s, LIM_S);
  assign drag_y_s = clamp_offset(raw_y_s, LIM_S);

  // Current value and ceiling of the setting selected by the last button press
  always_comb begin
    cur_val_s = delay_r;
    cur_max_s = SET_MAX_V;
    case (sel_r)
      SET_DELAY:  begin cur_val_s = delay_r;  cur_max_s = SET_MAX_V;  end
      SET_MODE:   begin cur_val_s = mode_r;   cur_max_s = MODE_MAX_V; end
      SET_CORNER: begin cur_val_s = corner_r; cur_max_s = SET_MAX_V;  end
      SET_AMP:    begin cur_val_s = amp_r;    cur_max_s = SET_MAX_V;  end
      SET_TIME:   begin cur_val_s = time_r;   cur_max_s = SET_MAX_V;  end
      default:    begin cur_val_s = delay_r;  cur_max_s = SET_MAX_V;  end
    endcase
  end

  assign new_val_s = step_setting(cur_val_s, cur_max_s, sel_plus_r);

  // Next-state and next-register logic of the press/drag/step sequencer
  always_comb begin
    state_s    = state_r;
    anchor_x_s = anchor_x_r;
    anchor_y_s = anchor_y_r;
    base_x_s   = base_x_r;
    base_y_s   = base_y_r;
    off_x_s    = off_x_r;
    off_y_s    = off_y_r;
    sel_s      = sel_r;
    sel_plus_s = sel_plus_r;
    delay_s    = delay_r;
    mode_s     = mode_r;
    corner_s   = corner_r;
    amp_s      = amp_r;
    time_s     = time_r;
    changed_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (press_s && chart_hit_s) begin
          anchor_x_s = bus.xpos;
          anchor_y_s = bus.ypos;
          state_s    = DRAG;
        end else if (press_s && btn_hit_s) begin
          sel_s      = setting_idx_t'(btn_row_s);
          sel_plus_s = btn_plus_s;
          state_s    = STEP;
        end else if (press_s) begin
          state_s = WAIT_RELEASE;
        end else begin
          state_s = IDLE;
        end
      end
      DRAG: begin
        off_x_s = drag_x_s[11:0];
        off_y_s = drag_y_s[11:0];
        if (!bus.left_mouse) begin
          base_x_s = drag_x_s[11:0];
          base_y_s = drag_y_s[11:0];
          state_s  = IDLE;
        end else begin
          state_s = DRAG;
        end
      end
      STEP: begin
        changed_s = (new_val_s != cur_val_s);
        case (sel_r)
          SET_DELAY:  delay_s  = new_val_s;
          SET_MODE:   mode_s   = new_val_s;
          SET_CORNER: corner_s = new_val_s;
          SET_AMP:    amp_s    = new_val_s;
          SET_TIME:   time_s   = new_val_s;
          default:    delay_s  = delay_r;
        endcase
        state_s = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!bus.left_mouse) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_RELEASE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  assign drag_active_s = (state_s == DRAG);

  // State and output registers; reset re-seeds the button history so a held button is not a press
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      left_prev_r   <= bus.left_mouse;
      anchor_x_r    <= 12'd0;
      anchor_y_r    <= 12'd0;
      base_x_r      <= 12'sd0;
      base_y_r      <= 12'sd0;
      off_x_r       <= 12'sd0;
      off_y_r       <= 12'sd0;
      drag_active_r <= 1'b0;
      sel_r         <= SET_DELAY;
      sel_plus_r    <= 1'b0;
      delay_r       <= 4'd0;
      mode_r        <= 4'd0;
      corner_r      <= 4'd0;
      amp_r         <= AMP_RST_V;
      time_r        <= TIME_RST_V;
      changed_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      left_prev_r   <= bus.left_mouse;
      anchor_x_r    <= anchor_x_s;
      anchor_y_r    <= anchor_y_s;
      base_x_r      <= base_x_s;
      base_y_r      <= base_y_s;
      off_x_r       <= off_x_s;
      off_y_r       <= off_y_s;
      drag_active_r <= drag_active_s;
      sel_r         <= sel_s;
      sel_plus_r    <= sel_plus_s;
      delay_r       <= delay_s;
      mode_r        <= mode_s;
      corner_r      <= corner_s;
      amp_r         <= amp_s;
      time_r        <= time_s;
      changed_r     <= changed_s;
    end
  end

  assign bus.offset_x         = off_x_r;
  assign bus.offset_y         = off_y_r;
  assign bus.drag_active      = drag_active_r;
  assign bus.delay            = delay_r;
  assign bus.mode             = mode_r;
  assign bus.corner_freq      = corner_r;
  assign bus.amplitude_scale  = amp_r;
  assign bus.time_scale       = time_r;
  assign bus.settings_changed = changed_r;

endmodule

// File: tb/tb_ui_control_fsm.sv
// Scoreboard bench for ui_control_fsm: a behavioural panel model predicts every output
// cycle; a negedge monitor compares snapshots and named spot checks.
module tb_ui_control_fsm;

  localparam int PH_IDLE = 0;
  localparam int PH_DRAG = 1;
  localparam int PH_STEP = 2;
  localparam int PH_WAIT = 3;

  localparam int F_OFFX   = 0;
  localparam int F_OFFY   = 1;
  localparam int F_DRAG   = 2;
  localparam int F_DELAY  = 3;
  localparam int F_MODE   = 4;
  localparam int F_AMP    = 5;
  localparam int F_TIME   = 6;
  localparam int F_PULSES = 7;

  typedef struct packed {
    logic [11:0] ox;
    logic [11:0] oy;
    logic        drag;
    logic [3:0]  dly;
    logic [3:0]  md;
    logic [3:0]  cf;
    logic [3:0]  amp;
    logic [3:0]  ts;
    logic        chg;
  } snap_t;

  typedef struct {
    string name;
    int    field;
    int    expv;
  } chk_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ui_control_fsm_if bus();

  ui_control_fsm dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  snap_t exp_q[$];
  chk_t  chk_q[$];
  int    checks = 0;
  int    errors = 0;
  int    pulses_total = 0;

  // Behavioural panel model
  int m_prev_l, m_phase, m_ax, m_ay, m_basex, m_basey, m_offx, m_offy;
  int m_row, m_plus, m_changed, m_pulses;
  int m_set[5];

  function automatic int clampi(input int v);
    if (v > 511) return 511;
    if (v < -511) return -511;
    return v;
  endfunction

  function automatic bit in_chart(input int x, input int y);
    return (x >= 64) && (x < 64 + 512) && (y >= 64) && (y < 64 + 384);
  endfunction

  function automatic bit button_at(input int x, input int y, output int row, output int col);
    int dx, dy;
    dx = x - 800;
    dy = y - 100;
    row = dy / 48;
    col = dx / 48;
    return (dx >= 0) && (dy >= 0) && (col < 2) && (row < 5) && (dx % 48 < 32) && (dy % 48 < 32);
  endfunction

  task automatic model_reset(input int l);
    m_prev_l = l; m_phase = PH_IDLE; m_ax = 0; m_ay = 0;
    m_basex = 0; m_basey = 0; m_offx = 0; m_offy = 0; m_changed = 0;
    m_set[0] = 0; m_set[1] = 0; m_set[2] = 0; m_set[3] = 4; m_set[4] = 4;
  endtask

  task automatic model_edge(input int r, input int l, input int x, input int y);
    int row, col, old, lim;
    bit press;
    m_changed = 0;
    if (r != 0) begin
      model_reset(l);
      return;
    end
    press = (l != 0) && (m_prev_l == 0);
    if (m_phase == PH_IDLE) begin
      if (press && in_chart(x, y)) begin
        m_ax = x; m_ay = y; m_phase = PH_DRAG;
      end else if (press && button_at(x, y, row, col)) begin
        m_row = row; m_plus = col; m_phase = PH_STEP;
      end else if (press) begin
        m_phase = PH_WAIT;
      end
    end else if (m_phase == PH_DRAG) begin
      m_offx = clampi(m_basex + x - m_ax);
      m_offy = clampi(m_basey + y - m_ay);
      if (l == 0) begin
        m_basex = m_offx; m_basey = m_offy; m_phase = PH_IDLE;
      end
    end else if (m_phase == PH_STEP) begin
      lim = (m_row == 1) ? 3 : 15;
      old = m_set[m_row];
      if (m_plus != 0) m_set[m_row] = (old + 1 > lim) ? lim : old + 1;
      else m_set[m_row] = (old - 1 < 0) ? 0 : old - 1;
      m_changed = (m_set[m_row] != old) ? 1 : 0;
      m_pulses += m_changed;
      m_phase = PH_WAIT;
    end else begin
      if (l == 0) m_phase = PH_IDLE;
    end
    m_prev_l = l;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.ox = 12'(m_offx); s.oy = 12'(m_offy);
    s.drag = (m_phase == PH_DRAG);
    s.dly = 4'(m_set[0]); s.md = 4'(m_set[1]); s.cf = 4'(m_set[2]);
    s.amp = 4'(m_set[3]); s.ts = 4'(m_set[4]);
    s.chg = (m_changed != 0);
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.ox = bus.offset_x; s.oy = bus.offset_y; s.drag = bus.drag_active;
    s.dly = bus.delay; s.md = bus.mode; s.cf = bus.corner_freq;
    s.amp = bus.amplitude_scale; s.ts = bus.time_scale; s.chg = bus.settings_changed;
    return s;
  endfunction

  function automatic int field_val(input int f);
    case (f)
      F_OFFX:  return int'($signed(bus.offset_x));
      F_OFFY:  return int'($signed(bus.offset_y));
      F_DRAG:  return int'(bus.drag_active);
      F_DELAY: return int'(bus.delay);
      F_MODE:  return int'(bus.mode);
      F_AMP:   return int'(bus.amplitude_scale);
      F_TIME:  return int'(bus.time_scale);
      default: return pulses_total;
    endcase
  endfunction

  // One clock of stimulus; the model's prediction for that edge goes to the scoreboard
  task automatic tick(input int r, input int l, input int x, input int y);
    rst = (r != 0);
    bus.left_mouse = (l != 0);
    bus.xpos = 12'(x);
    bus.ypos = 12'(y);
    @(posedge clk);
    model_edge(r, l, x, y);
    exp_q.push_back(model_snap());
    #1;
  endtask

  task automatic expect_field(input string name, input int field, input int expv);
    chk_q.push_back('{name, field, expv});
  endtask

  task automatic click(input int x, input int y, input int hold);
    tick(0, 0, x, y);
    for (int i = 0; i < hold; i++) tick(0, 1, x, y);
    tick(0, 0, x, y);
  endtask

  snap_t mon_e, mon_a;
  chk_t  mon_c;
  int    mon_v;

  // Monitor: compares the model's prediction for each edge, then any queued spot checks
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_a = dut_snap();
      if (mon_a === 46'(0) || mon_a !== mon_a) begin end
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL snapshot t=%0t got %h expected %h", $time, mon_a, mon_e);
      end
      if (bus.settings_changed === 1'b1) pulses_total++;
    end
    while (chk_q.size() != 0) begin
      mon_c = chk_q.pop_front();
      mon_v = field_val(mon_c.field);
      checks++;
      if (mon_v != mon_c.expv) begin
        errors++;
        $display("FAIL %s got %0d expected %0d", mon_c.name, mon_v, mon_c.expv);
      end
    end
  end

  int base_p, kind, rr, cc, xx, yy, hold, moves;

  initial begin
    m_pulses = 0;
    model_reset(1);
    // Reset with the button held: no drag until a fresh rising edge
    tick(1, 1, 100, 100);
    tick(1, 1, 100, 100);
    expect_field("rst_offx", F_OFFX, 0);
    expect_field("rst_offy", F_OFFY, 0);
    expect_field("rst_amp", F_AMP, 4);
    expect_field("rst_time", F_TIME, 4);
    expect_field("rst_delay", F_DELAY, 0);
    expect_field("rst_mode", F_MODE, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 100, 100);
    expect_field("held_no_drag", F_DRAG, 0);
    // Drag sessions
    tick(0, 0, 100, 100);
    tick(0, 1, 100, 100);
    expect_field("drag_start", F_DRAG, 1);
    tick(0, 1, 150, 80);
    expect_field("drag1_x", F_OFFX, 50);
    expect_field("drag1_y", F_OFFY, -20);
    tick(0, 0, 150, 80);
    tick(0, 1, 200, 200);
    tick(0, 1, 190, 210);
    expect_field("drag2_x", F_OFFX, 40);
    expect_field("drag2_y", F_OFFY, -10);
    tick(0, 0, 190, 210);
    // Clamp and commit
    tick(1, 0, 70, 70);
    tick(0, 0, 70, 70);
    tick(0, 1, 70, 70);
    tick(0, 1, 700, 70);
    expect_field("clamp_pos", F_OFFX, 511);
    tick(0, 1, 0, 70);
    expect_field("clamp_neg", F_OFFX, -70);
    tick(0, 0, 0, 70);
    tick(0, 1, 300, 300);
    tick(0, 1, 310, 300);
    expect_field("base_kept_x", F_OFFX, -60);
    expect_field("base_kept_y", F_OFFY, 0);
    tick(0, 0, 310, 300);
    // Saturating steps
    base_p = m_pulses;
    for (int i = 0; i < 20; i++) click(860, 254, 2);
    expect_field("amp_sat", F_AMP, 15);
    expect_field("amp_pulses", F_PULSES, base_p + 11);
    base_p = m_pulses;
    click(810, 158, 2);
    expect_field("mode_floor", F_MODE, 0);
    expect_field("mode_no_pulse", F_PULSES, base_p);
    // Long hold gives one step
    base_p = m_pulses;
    tick(0, 0, 860, 110);
    for (int i = 0; i < 101; i++) tick(0, 1, 860, 110);
    expect_field("hold_delay", F_DELAY, 1);
    expect_field("hold_pulses", F_PULSES, base_p + 1);
    tick(0, 0, 860, 110);
    // Miss, then drag into the chart while held
    tick(0, 1, 700, 10);
    for (int i = 0; i < 5; i++) tick(0, 1, 300 + i * 10, 300);
    expect_field("miss_offx", F_OFFX, -60);
    expect_field("miss_drag", F_DRAG, 0);
    tick(0, 0, 340, 300);
    // Reset in the middle of a drag
    tick(0, 1, 200, 200);
    tick(0, 1, 260, 230);
    expect_field("pre_rst_offy", F_OFFY, 30);
    tick(1, 1, 260, 230);
    expect_field("mid_rst_offx", F_OFFX, 0);
    expect_field("mid_rst_offy", F_OFFY, 0);
    expect_field("mid_rst_drag", F_DRAG, 0);
    tick(0, 1, 300, 300);
    expect_field("post_rst_held", F_DRAG, 0);
    tick(0, 0, 300, 300);
    // Randomised traffic, including window/button edges and stray resets
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 19);
      if (kind < 8) begin
        rr = $urandom_range(0, 4);
        cc = $urandom_range(0, 1);
        xx = 800 + cc * 48 + $urandom_range(0, 33) - 1;
        yy = 100 + rr * 48 + $urandom_range(0, 33) - 1;
        hold = $urandom_range(1, 4);
        click(xx, yy, hold);
      end else if (kind < 16) begin
        xx = 63 + $urandom_range(0, 514);
        yy = 63 + $urandom_range(0, 386);
        tick(0, 0, xx, yy);
        tick(0, 1, xx, yy);
        moves = $urandom_range(1, 6);
        for (int i = 0; i < moves; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            xx = $urandom_range(0, 4095);
            yy = $urandom_range(0, 4095);
          end else begin
            xx = $urandom_range(0, 700);
            yy = $urandom_range(0, 500);
          end
          tick(0, 1, xx, yy);
        end
        tick(0, 0, xx, yy);
      end else if (kind < 19) begin
        click($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(1, 3));
      end else begin
        tick(1, $urandom_range(0, 1), 300, 300);
        tick(0, 0, 300, 300);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ui_control_fsm.md
Name: ui_control_fsm

Overview:
- Mouse-driven control sequencer for the oscilloscope front panel.
- Decodes left-button press edges against the chart window and a 5x2 on-screen button panel.
- Chart presses run a drag session that produces a signed chart offset, committed on release.
- Button presses step one scope setting (delay, mode, corner_freq, amplitude_scale, time_scale) by +/-1, saturating.
- Sits between the mouse/VGA position logic and the chart renderer / filter / trigger datapath, which consume its registered settings.

Parameters:
- CHART_X0, 64: chart window left edge (px).
- CHART_Y0, 64: chart window top edge (px).
- CHART_W, 512: chart window width.
- CHART_H, 384: chart window height.
- BTN_X0, 800: minus-button column left edge; plus column starts at BTN_X0+BTN_PITCH.
- BTN_Y0, 100: row 0 top edge.
- BTN_W, 32: button width.
- BTN_H, 32: button height.
- BTN_PITCH, 48: row and column pitch.
- OFFSET_LIM, 511: offset clamp magnitude.
- SET_MAX, 15: max value of delay, corner_freq, amplitude_scale, time_scale.
- MODE_MAX, 3: max value of mode.
- DEF_AMP, 4: reset value of amplitude_scale.
- DEF_TIME, 4: reset value of time_scale.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- left_mouse  in  1  left button level, already in clk domain.
- xpos  in  12  cursor x.
- ypos  in  12  cursor y.
- offset_x  out  12  signed chart x offset.
- offset_y  out  12  signed chart y offset.
- drag_active  out  1  high while a drag session runs.
- delay  out  4  trigger delay setting.
- mode  out  4  display mode.
- corner_freq  out  4  filter corner select.
- amplitude_scale  out  4  vertical scale.
- time_scale  out  4  horizontal scale.
- settings_changed  out  1  one-cycle pulse when any setting changes.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - all outputs 0, except amplitude_scale=DEF_AMP and time_scale=DEF_TIME;
  - state=IDLE; anchor and base offsets cleared;
  - left_mouse history register loaded with current left_mouse.
- Press edge: press = left_mouse & ~left_prev. Level-high at reset never counts as a press.
- Hit decode (half-open ranges):
  - chart = x in [CHART_X0, CHART_X0+CHART_W) and y in [CHART_Y0, CHART_Y0+CHART_H).
  - Button row r (0..4) = y in [BTN_Y0+r*BTN_PITCH, +BTN_H).
  - Column minus = x in [BTN_X0, +BTN_W); column plus = x in [BTN_X0+BTN_PITCH, +BTN_W).
  - Rows map: 0 delay, 1 mode, 2 corner_freq, 3 amplitude_scale, 4 time_scale.
- IDLE, on press:
  - chart hit: latch anchor=(xpos,ypos) -> DRAG.
  - button hit: -> STEP.
  - no hit: -> WAIT_RELEASE.
- DRAG:
  - Each cycle, offset = clamp(base + pos - anchor, -OFFSET_LIM, +OFFSET_LIM), computed at 14 bits signed, then registered.
  - Output lags the sampled position by 1 cycle.
  - Cursor leaving the chart does not end the drag.
  - drag_active=1.
  - On left_mouse=0: base <= current clamped offset, -> IDLE.
- STEP (exactly 1 cycle):
  - Selected setting +1 or -1, saturating at 0 and at SET_MAX (MODE_MAX for mode).
  - settings_changed=1 only if the value actually changed.
  - Then -> WAIT_RELEASE.
- WAIT_RELEASE: hold until left_mouse=0, then -> IDLE. Holding the button gives exactly one step.
- Press-to-setting latency: 2 cycles.
- No simultaneous requests are possible: a press is accepted only in IDLE.
- Reset mid-drag or mid-step: immediate return to reset values; no pending commit.

Decomposition:
- Shared vga package holds:
  - state typedef ui_state_t {IDLE, DRAG, STEP, WAIT_RELEASE};
  - setting index enum setting_idx_t;
  - chart and button geometry defaults, so renderer and controller agree.
- Sub-module ui_hit_decoder: combinational; outputs chart_hit, btn_hit, btn_row[2:0], btn_plus.

Test Plan:
- Reset: assert rst 2 cycles with left_mouse=1 -> offsets 0, delay/mode/corner_freq 0, amplitude_scale 4, time_scale 4, drag_active 0; no drag until a new rising edge.
- Drag: press at (100,100), move to (150,80) -> offset (50,-20) one cycle later. Release, press (200,200), move to (190,210) -> offset (40,-10).
- Clamp: press (70,70), move to (700,70) -> offset_x=+511. Move to (0,70) -> offset_x=-70. Release -> base holds -70.
- Saturation: 20 separated clicks at plus/amplitude (860,254) -> amplitude_scale reaches 15, settings_changed pulses exactly 11 times. Mode minus (810,158) from 0 -> stays 0, no pulse.
- Hold: press at (860,110), hold 100 cycles -> delay=1, single pulse, state WAIT_RELEASE until release.
- Miss and mid-op reset: press at (700,10), drag into chart while held -> no offset change. Assert rst during a drag -> offsets 0 next cycle, state IDLE.
